// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg: opcode, funct, ALU-op and controller state encodings        |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package mips_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BGTZ  = 6'b000111;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_XOR = 6'b100110;
    localparam logic [5:0] c_FN_NOR = 6'b100111;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mc_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_control_if: controller <-> datapath signal bundle                  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
interface mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       gtz;
    logic       mem_ready;
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsource;
    logic [3:0] state;

    // master is the controller, slave is the datapath
    modport master (
        input  opcode, funct, zero, gtz, mem_ready,
        output pcen, iord, memread, memwrite, irwrite, regdst, memtoreg,
               regwrite, alusrca, alusrcb, alucontrol, pcsource, state
    );
    modport slave (
        output opcode, funct, zero, gtz, mem_ready,
        input  pcen, iord, memread, memwrite, irwrite, regdst, memtoreg,
               regwrite, alusrca, alusrcb, alucontrol, pcsource, state
    );
endinterface
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_alu_dec: R-type funct field to ALU operation (combinational)       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module mc_alu_dec
    import mips_pkg::*;
(
    input  wire logic [5:0] i_funct,
    output logic      [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_funct)
            c_FN_ADD: o_alucontrol = ALU_ADD;
            c_FN_SUB: o_alucontrol = ALU_SUB;
            c_FN_AND: o_alucontrol = ALU_AND;
            c_FN_OR:  o_alucontrol = ALU_OR;
            c_FN_XOR: o_alucontrol = ALU_XOR;
            c_FN_NOR: o_alucontrol = ALU_NOR;
            c_FN_SLT: o_alucontrol = ALU_SLT;
            default:  o_alucontrol = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_control: multicycle MIPS-subset controller FSM and output decode   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module mc_control
    import mips_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst,
    mc_control_if.master bus
);

    state_e     r_state_q;
    state_e     w_state_d;
    state_e     w_cur;
    logic [2:0] w_rtex_alu;

    mc_alu_dec u_alu_dec (
        .i_funct      (bus.funct),
        .o_alucontrol (w_rtex_alu)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state_q <= S_FETCH;
        else     r_state_q <= w_state_d;
    end

    // While reset is held the strobes decode as FETCH so no write can leak out
    assign w_cur     = rst ? S_FETCH : r_state_q;
    assign bus.state = r_state_q;

    always_comb begin
        w_state_d      = w_cur;
        bus.pcen       = 1'b0;
        bus.iord       = 1'b0;
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'd0;
        bus.alucontrol = 3'd0;
        bus.pcsource   = 2'd0;
        case (w_cur)
            S_FETCH: begin
                bus.memread    = 1'b1;
                bus.alusrcb    = 2'd1;
                bus.alucontrol = ALU_ADD;
                if (bus.mem_ready && !rst) begin
                    bus.irwrite = 1'b1;
                    bus.pcen    = 1'b1;
                    w_state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alusrcb    = 2'd3;
                bus.alucontrol = ALU_ADD;
                case (bus.opcode)
                    c_OP_LW, c_OP_SW:    w_state_d = S_MEMADR;
                    c_OP_RTYPE:          w_state_d = S_RTEX;
                    c_OP_BEQ, c_OP_BGTZ: w_state_d = S_BRANCH;
                    c_OP_ADDI:           w_state_d = S_ADDIEX;
                    c_OP_J:              w_state_d = S_JUMP;
                    default:             w_state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'd2;
                bus.alucontrol = ALU_ADD;
                w_state_d      = (bus.opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord    = 1'b1;
                bus.memread = 1'b1;
                if (bus.mem_ready) w_state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                w_state_d    = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                if (bus.mem_ready) w_state_d = S_FETCH;
            end
            S_RTEX: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = w_rtex_alu;
                w_state_d      = S_RTWB;
            end
            S_RTWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                w_state_d    = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = ALU_SUB;
                bus.pcsource   = 2'd1;
                bus.pcen       = (bus.opcode == c_OP_BEQ)  ? bus.zero :
                                 (bus.opcode == c_OP_BGTZ) ? bus.gtz  : 1'b0;
                w_state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'd2;
                bus.alucontrol = ALU_ADD;
                w_state_d      = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.regwrite = 1'b1;
                w_state_d    = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsource = 2'd2;
                bus.pcen     = 1'b1;
                w_state_d    = S_FETCH;
            end
            default: w_state_d = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire
